// File: rtl/com_tick_pkg.sv
// Shared constants for the tick scheduler: register map, CONTROL bit layout and channel limit.
package com_tick_pkg;

  localparam int unsigned MAX_CH = 4;

  localparam logic [3:0] STATUS      = 4'd0;
  localparam logic [3:0] CONTROL     = 4'd1;
  localparam logic [3:0] CHEN        = 4'd2;
  localparam logic [3:0] PERIOD_BASE = 4'd4;
  localparam logic [3:0] COUNT_BASE  = 4'd8;

  localparam int unsigned CTRL_GEN_BIT   = 0;
  localparam int unsigned CTRL_IEN_BIT   = 1;
  localparam int unsigned STATUS_OVR_LSB = 4;

  // One-hot decode of a register write strobe
  typedef struct packed {
    logic              status;
    logic              control;
    logic              chen;
    logic [MAX_CH-1:0] period;
  } wr_dec_t;

endpackage

// File: rtl/com_tick_scheduler_if.sv
// Avalon-MM slave bus, interrupt and expiry event stream of the tick scheduler.
interface com_tick_scheduler_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;
  logic        ev_valid;
  logic [1:0]  ev_ch;
  logic        ev_ready;

  modport slave (
    input  address, chipselect, write_n, writedata, ev_ready,
    output readdata, irq, ev_valid, ev_ch
  );

  modport master (
    output address, chipselect, write_n, writedata, ev_ready,
    input  readdata, irq, ev_valid, ev_ch
  );
endinterface

// File: rtl/com_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after last+1, wrapping.
module com_rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] last,
  output logic            grant_valid,
  output logic [IdxW-1:0] grant_idx
);

  logic [N-1:0] req_rot;
  int unsigned  shift;
  int unsigned  first;

  always_comb begin
    shift       = (32'(last) + 1) % N;
    // Rotate so bit 0 is the channel right after the last grant
    req_rot     = N'({req, req} >> shift);
    first       = 0;
    grant_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!grant_valid && req_rot[i]) begin
        grant_valid = 1'b1;
        first       = i;
      end
    end
    grant_idx = IdxW'((shift + first) % N);
  end

endmodule

// File: rtl/com_tick_scheduler.sv
// Multi-channel timeout scheduler sharing one periodic tick; reports expiries by IRQ and by a
// round-robin valid/ready event stream.
module com_tick_scheduler
  import com_tick_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 tick_in,
  com_tick_scheduler_if.slave bus
);

  typedef logic [CNT_W-1:0] cnt_t;

  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] overrun_q, overrun_d;
  logic [NUM_CH-1:0] req_q, req_d;
  logic [NUM_CH-1:0] chen_q, chen_d;
  logic              gen_q, gen_d;
  logic              ien_q, ien_d;
  cnt_t              period_q [NUM_CH];
  cnt_t              period_d [NUM_CH];
  cnt_t              count_q  [NUM_CH];
  cnt_t              count_d  [NUM_CH];
  logic [1:0]        last_q, last_d;
  logic              ev_valid_q, ev_valid_d;
  logic [1:0]        ev_ch_q, ev_ch_d;
  logic [15:0]       readdata_q, readdata_d;

  logic              we;
  wr_dec_t           dec;
  logic [NUM_CH-1:0] expire;
  logic [NUM_CH-1:0] chen_rise;
  logic [NUM_CH-1:0] accept_mask;
  logic [NUM_CH-1:0] req_avail;
  logic [NUM_CH-1:0] w1c_pend, w1c_ovr;
  logic              accept;
  logic              load;
  logic              grant_valid;
  logic [1:0]        grant_idx;

  assign we = bus.chipselect && !bus.write_n;

  always_comb begin
    dec = '0;
    if (we) begin
      dec.status  = (bus.address == STATUS);
      dec.control = (bus.address == CONTROL);
      dec.chen    = (bus.address == CHEN);
      for (int unsigned c = 0; c < MAX_CH; c++) begin
        dec.period[c] = (bus.address == PERIOD_BASE + 4'(c));
      end
    end
  end

  assign chen_rise = dec.chen ? (bus.writedata[NUM_CH-1:0] & ~chen_q) : '0;
  assign chen_d    = dec.chen ? bus.writedata[NUM_CH-1:0] : chen_q;
  assign gen_d     = dec.control ? bus.writedata[CTRL_GEN_BIT] : gen_q;
  assign ien_d     = dec.control ? bus.writedata[CTRL_IEN_BIT] : ien_q;

  // Priority per channel: PERIOD write, then enable rise, then tick countdown
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      period_d[c] = period_q[c];
      count_d[c]  = count_q[c];
      expire[c]   = 1'b0;
      if (dec.period[c]) begin
        period_d[c] = bus.writedata[CNT_W-1:0];
        count_d[c]  = bus.writedata[CNT_W-1:0];
      end else if (chen_rise[c]) begin
        count_d[c] = period_q[c];
      end else if (tick_in && gen_q && chen_q[c] && (period_q[c] != '0)) begin
        if (count_q[c] <= cnt_t'(1)) begin
          count_d[c] = period_q[c];
          expire[c]  = 1'b1;
        end else begin
          count_d[c] = count_q[c] - cnt_t'(1);
        end
      end
    end
  end

  assign accept = ev_valid_q && bus.ev_ready;
  assign load   = !ev_valid_q || bus.ev_ready;

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      accept_mask[c] = accept && (ev_ch_q == 2'(c));
    end
  end

  assign req_avail = req_q & ~accept_mask;

  com_rr_arbiter #(
    .N    (NUM_CH),
    .IdxW (2)
  ) u_arb (
    .req         (req_avail),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // New expiries join req after the search, so they surface one cycle later
  always_comb begin
    w1c_pend = '0;
    w1c_ovr  = '0;
    if (dec.status) begin
      w1c_pend = bus.writedata[NUM_CH-1:0];
      w1c_ovr  = bus.writedata[STATUS_OVR_LSB +: NUM_CH];
    end
    req_d     = req_avail | expire;
    pending_d = (pending_q & ~w1c_pend) | expire;
    overrun_d = (overrun_q & ~w1c_ovr) | (expire & req_q & ~accept_mask);
  end

  always_comb begin
    ev_valid_d = ev_valid_q;
    ev_ch_d    = ev_ch_q;
    last_d     = last_q;
    if (load) begin
      ev_valid_d = grant_valid;
      if (grant_valid) begin
        ev_ch_d = grant_idx;
        last_d  = grant_idx;
      end
    end
  end

  always_comb begin
    readdata_d = '0;
    if (bus.address == STATUS) begin
      readdata_d[NUM_CH-1:0]                = pending_q;
      readdata_d[STATUS_OVR_LSB +: NUM_CH] = overrun_q;
    end else if (bus.address == CONTROL) begin
      readdata_d[CTRL_GEN_BIT] = gen_q;
      readdata_d[CTRL_IEN_BIT] = ien_q;
    end else if (bus.address == CHEN) begin
      readdata_d[NUM_CH-1:0] = chen_q;
    end
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (bus.address == PERIOD_BASE + 4'(c)) readdata_d[CNT_W-1:0] = period_q[c];
      if (bus.address == COUNT_BASE + 4'(c))  readdata_d[CNT_W-1:0] = count_q[c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      overrun_q  <= '0;
      req_q      <= '0;
      chen_q     <= '0;
      gen_q      <= 1'b0;
      ien_q      <= 1'b0;
      last_q     <= 2'(NUM_CH - 1);
      ev_valid_q <= 1'b0;
      ev_ch_q    <= '0;
      readdata_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        period_q[c] <= '0;
        count_q[c]  <= '0;
      end
    end else begin
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      req_q      <= req_d;
      chen_q     <= chen_d;
      gen_q      <= gen_d;
      ien_q      <= ien_d;
      last_q     <= last_d;
      ev_valid_q <= ev_valid_d;
      ev_ch_q    <= ev_ch_d;
      readdata_q <= readdata_d;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        period_q[c] <= period_d[c];
        count_q[c]  <= count_d[c];
      end
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = ien_q && (|pending_q);
  assign bus.ev_valid = ev_valid_q;
  assign bus.ev_ch    = ev_ch_q;

endmodule

// File: tb/tb_com_tick_scheduler.sv
// Bench for com_tick_scheduler: directed scenarios plus a randomized run against a reference model.
module tb_com_tick_scheduler;
  import com_tick_pkg::*;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic tick_in = 1'b0;

  com_tick_scheduler_if bus();

  com_tick_scheduler #(
    .NUM_CH (4),
    .CNT_W  (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tick_in (tick_in),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state, updated once per clock edge from the rules of the register map
  int          m_period [4];
  int          m_count  [4];
  bit [3:0]    m_pend, m_ovr, m_req, m_chen;
  bit          m_gen, m_ien, m_valid;
  int          m_ch, m_last;
  logic [15:0] m_rd;

  function automatic logic [15:0] model_read(input logic [3:0] a);
    if (a == 4'd0) return {8'h00, m_ovr, m_pend};
    if (a == 4'd1) return {14'd0, m_ien, m_gen};
    if (a == 4'd2) return {12'd0, m_chen};
    if (a >= 4'd4 && a <= 4'd7) return 16'(m_period[a - 4'd4]);
    if (a >= 4'd8 && a <= 4'd11) return 16'(m_count[a - 4'd8]);
    return 16'h0000;
  endfunction

  task automatic model_step(input bit rst, input bit tk, input bit cs, input bit wn,
                            input logic [3:0] a, input logic [15:0] wd, input bit rdy);
    bit       we, accept;
    bit [3:0] fired, avail, clr_p, clr_o, new_ovr;
    int       best, best_d, d;
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        m_period[c] = 0;
        m_count[c]  = 0;
      end
      {m_pend, m_ovr, m_req, m_chen} = '0;
      {m_gen, m_ien, m_valid} = '0;
      m_ch   = 0;
      m_last = 3;
      m_rd   = 16'h0;
      return;
    end
    m_rd   = model_read(a);
    we     = cs && !wn;
    accept = m_valid && rdy;
    fired  = '0;
    for (int c = 0; c < 4; c++) begin
      if (we && a == 4'(4 + c)) begin
        m_count[c] = wd;
      end else if (we && a == 4'd2 && wd[c] && !m_chen[c]) begin
        m_count[c] = m_period[c];
      end else if (tk && m_gen && m_chen[c] && m_period[c] != 0) begin
        if (m_count[c] <= 1) begin
          m_count[c] = m_period[c];
          fired[c]   = 1'b1;
        end else begin
          m_count[c] = m_count[c] - 1;
        end
      end
    end
    avail = m_req;
    if (accept) avail[m_ch] = 1'b0;
    new_ovr = '0;
    for (int c = 0; c < 4; c++) begin
      if (fired[c] && m_req[c] && !(accept && m_ch == c)) new_ovr[c] = 1'b1;
    end
    if (!m_valid || rdy) begin
      best   = -1;
      best_d = 99;
      for (int c = 0; c < 4; c++) begin
        d = (c - m_last - 1 + 8) % 4;
        if (avail[c] && d < best_d) begin
          best   = c;
          best_d = d;
        end
      end
      m_valid = (best >= 0);
      if (best >= 0) begin
        m_ch   = best;
        m_last = best;
      end
    end
    clr_p = (we && a == 4'd0) ? wd[3:0] : 4'h0;
    clr_o = (we && a == 4'd0) ? wd[7:4] : 4'h0;
    m_pend = (m_pend & ~clr_p) | fired;
    m_ovr  = (m_ovr & ~clr_o) | new_ovr;
    m_req  = avail | fired;
    if (we && a == 4'd1) begin
      m_gen = wd[0];
      m_ien = wd[1];
    end
    if (we && a == 4'd2) m_chen = wd[3:0];
    for (int c = 0; c < 4; c++) begin
      if (we && a == 4'(4 + c)) m_period[c] = wd;
    end
  endtask

  task automatic step();
    model_step(reset, tick_in, bus.chipselect, bus.write_n, bus.address, bus.writedata,
               bus.ev_ready);
    @(posedge clk);
    #1;
    tick_in        = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    step();
  endtask

  task automatic rd(input logic [3:0] a, output logic [15:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    step();
    d = bus.readdata;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.ev_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    do_reset();
    checks++;
    if (bus.readdata !== 16'h0) begin
      errors++; $display("FAIL reset_readdata: got %0h expected 0", bus.readdata);
    end
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b expected 0", bus.irq); end
    checks++;
    if (bus.ev_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ev_valid: got %0b expected 0", bus.ev_valid);
    end
    checks++;
    if (bus.ev_ch !== 2'd0) begin errors++; $display("FAIL reset_ev_ch: got %0d expected 0", bus.ev_ch); end
    for (int a = 0; a < 12; a++) begin
      rd(4'(a), v);
      checks++;
      if (v !== 16'h0) begin errors++; $display("FAIL reset_reg%0d: got %0h expected 0", a, v); end
    end
  endtask

  task automatic test_single_channel();
    logic [15:0] v;
    int          seen, exp_seen, exp_cnt;
    do_reset();
    bus.ev_ready = 1'b1;
    wr(PERIOD_BASE, 16'd3);
    wr(CHEN, 16'h0001);
    wr(CONTROL, 16'h0001);
    rd(COUNT_BASE, v);
    checks++;
    if (v !== 16'd3) begin errors++; $display("FAIL single_count_init: got %0d expected 3", v); end
    for (int k = 1; k <= 9; k++) begin
      bus.address = COUNT_BASE;
      tick_in     = 1'b1;
      step();
      seen = (bus.ev_valid && bus.ev_ch == 2'd0) ? 1 : 0;
      for (int j = 0; j < 9; j++) begin
        step();
        if (j == 0) begin
          exp_cnt = (k % 3 == 0) ? 3 : 3 - (k % 3);
          checks++;
          if (bus.readdata !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL single_count_tick%0d: got %0d expected %0d", k, bus.readdata, exp_cnt);
          end
        end
        if (bus.ev_valid && bus.ev_ch == 2'd0) seen++;
      end
      exp_seen = (k % 3 == 0) ? 1 : 0;
      checks++;
      if (seen != exp_seen) begin
        errors++; $display("FAIL single_events_tick%0d: got %0d expected %0d", k, seen, exp_seen);
      end
    end
    rd(STATUS, v);
    checks++;
    if (v !== 16'h0001) begin errors++; $display("FAIL single_status: got %0h expected 0001", v); end
  endtask

  task automatic test_backpressure();
    logic [15:0] v;
    int          order[$];
    do_reset();
    for (int c = 0; c < 4; c++) wr(PERIOD_BASE + 4'(c), 16'd1);
    wr(CHEN, 16'h000F);
    wr(CONTROL, 16'h0001);
    bus.ev_ready = 1'b0;
    tick_in      = 1'b1;
    step();
    for (int j = 0; j < 6; j++) begin
      if (j == 2) tick_in = 1'b1;
      step();
      checks++;
      if (!(bus.ev_valid === 1'b1 && bus.ev_ch === 2'd0)) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%0b ch=%0d expected valid=1 ch=0", j, bus.ev_valid,
                 bus.ev_ch);
      end
    end
    rd(STATUS, v);
    checks++;
    if (v !== 16'h00FF) begin errors++; $display("FAIL bp_overrun: got %0h expected 00ff", v); end
    bus.ev_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      if (bus.ev_valid) order.push_back(int'(bus.ev_ch));
      step();
    end
    checks++;
    if (order.size() != 4) begin
      errors++; $display("FAIL bp_count: got %0d expected 4", order.size());
    end
    for (int i = 0; i < order.size() && i < 4; i++) begin
      checks++;
      if (order[i] != i) begin errors++; $display("FAIL bp_order%0d: got %0d expected %0d", i, order[i], i); end
    end
  endtask

  task automatic test_round_robin();
    int seq[$];
    do_reset();
    bus.ev_ready = 1'b1;
    wr(PERIOD_BASE + 4'd0, 16'd1);
    wr(PERIOD_BASE + 4'd2, 16'd1);
    wr(CHEN, 16'h0005);
    wr(CONTROL, 16'h0001);
    for (int t = 0; t < 4; t++) begin
      tick_in = 1'b1;
      step();
      for (int j = 0; j < 6; j++) begin
        if (bus.ev_valid) seq.push_back(int'(bus.ev_ch));
        step();
      end
    end
    checks++;
    if (seq.size() != 8) begin errors++; $display("FAIL rr_count: got %0d expected 8", seq.size()); end
    for (int i = 0; i < seq.size() && i < 8; i++) begin
      checks++;
      if (seq[i] != ((i % 2) * 2)) begin
        errors++; $display("FAIL rr_seq%0d: got %0d expected %0d", i, seq[i], (i % 2) * 2);
      end
    end
  endtask

  task automatic test_w1c_collision();
    logic [15:0] v;
    do_reset();
    bus.ev_ready = 1'b1;
    wr(PERIOD_BASE, 16'd1);
    wr(CHEN, 16'h0001);
    wr(CONTROL, 16'h0003);
    tick_in = 1'b1;
    step();
    repeat (4) step();
    tick_in = 1'b1;
    wr(STATUS, 16'h0001);
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_kept: got %0b expected 1", bus.irq); end
    rd(STATUS, v);
    checks++;
    if (v !== 16'h0001) begin errors++; $display("FAIL w1c_pending_kept: got %0h expected 0001", v); end
    wr(STATUS, 16'h0001);
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL w1c_irq_drop: got %0b expected 0", bus.irq); end
    rd(STATUS, v);
    checks++;
    if (v !== 16'h0000) begin errors++; $display("FAIL w1c_cleared: got %0h expected 0", v); end
  endtask

  task automatic test_period_on_tick();
    logic [15:0] v;
    do_reset();
    bus.ev_ready = 1'b1;
    wr(PERIOD_BASE + 4'd1, 16'd1);
    wr(CHEN, 16'h0002);
    wr(CONTROL, 16'h0003);
    tick_in = 1'b1;
    wr(PERIOD_BASE + 4'd1, 16'd5);
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL pw_no_expiry: got irq %0b expected 0", bus.irq); end
    step();
    checks++;
    if (bus.ev_valid !== 1'b0) begin
      errors++; $display("FAIL pw_no_event: got %0b expected 0", bus.ev_valid);
    end
    rd(COUNT_BASE + 4'd1, v);
    checks++;
    if (v !== 16'd5) begin errors++; $display("FAIL pw_count: got %0d expected 5", v); end
    tick_in = 1'b1;
    step();
    rd(COUNT_BASE + 4'd1, v);
    checks++;
    if (v !== 16'd4) begin errors++; $display("FAIL pw_count_dec: got %0d expected 4", v); end
    rd(STATUS, v);
    checks++;
    if (v !== 16'h0000) begin errors++; $display("FAIL pw_status: got %0h expected 0", v); end
  endtask

  task automatic test_reset_mid_handshake();
    logic [15:0] v;
    do_reset();
    wr(PERIOD_BASE + 4'd2, 16'd1);
    wr(CHEN, 16'h0004);
    wr(CONTROL, 16'h0003);
    bus.ev_ready = 1'b0;
    tick_in      = 1'b1;
    step();
    bus.address = COUNT_BASE + 4'd2;
    step();
    checks++;
    if (!(bus.ev_valid === 1'b1 && bus.ev_ch === 2'd2 && bus.irq === 1'b1)) begin
      errors++;
      $display("FAIL rm_setup: got valid=%0b ch=%0d irq=%0b expected 1 2 1", bus.ev_valid,
               bus.ev_ch, bus.irq);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({bus.readdata, bus.irq, bus.ev_valid, bus.ev_ch} !== 20'h0) begin
      errors++;
      $display("FAIL rm_outputs: got rd=%0h irq=%0b valid=%0b ch=%0d expected all 0",
               bus.readdata, bus.irq, bus.ev_valid, bus.ev_ch);
    end
    rd(STATUS, v);
    checks++;
    if (v !== 16'h0) begin errors++; $display("FAIL rm_status: got %0h expected 0", v); end
    for (int c = 0; c < 4; c++) begin
      rd(COUNT_BASE + 4'(c), v);
      checks++;
      if (v !== 16'h0) begin errors++; $display("FAIL rm_count%0d: got %0h expected 0", c, v); end
    end
    checks++;
    if (bus.ev_valid !== 1'b0) begin
      errors++; $display("FAIL rm_stays_idle: got %0b expected 0", bus.ev_valid);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int c = 0; c < 4; c++) wr(PERIOD_BASE + 4'(c), 16'($urandom_range(0, 4)));
    wr(CHEN, 16'($urandom_range(0, 15)));
    wr(CONTROL, 16'h0003);
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick_in      = ($urandom_range(0, 2) == 0);
      bus.ev_ready = 1'($urandom_range(0, 1));
      bus.address  = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 31);
      if (r <= 3) begin
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        case (r)
          0: begin bus.address = STATUS; bus.writedata = 16'($urandom); end
          1: begin bus.address = CHEN; bus.writedata = 16'($urandom_range(0, 15)); end
          2: begin
            bus.address   = PERIOD_BASE + 4'($urandom_range(0, 3));
            bus.writedata = 16'($urandom_range(0, 4));
          end
          default: begin bus.address = CONTROL; bus.writedata = 16'($urandom_range(2, 3)); end
        endcase
      end else begin
        bus.chipselect = 1'($urandom_range(0, 1));
        bus.write_n    = 1'b1;
      end
      step();
      checks++;
      if (bus.ev_valid !== m_valid) begin
        errors++; $display("FAIL rnd_valid@%0d: got %0b expected %0b", cyc, bus.ev_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (bus.ev_ch !== 2'(m_ch)) begin
          errors++; $display("FAIL rnd_ch@%0d: got %0d expected %0d", cyc, bus.ev_ch, m_ch);
        end
      end
      checks++;
      if (bus.irq !== (m_ien && (|m_pend))) begin
        errors++;
        $display("FAIL rnd_irq@%0d: got %0b expected %0b", cyc, bus.irq, m_ien && (|m_pend));
      end
      checks++;
      if (bus.readdata !== m_rd) begin
        errors++; $display("FAIL rnd_readdata@%0d: got %0h expected %0h", cyc, bus.readdata, m_rd);
      end
    end
  endtask

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    bus.ev_ready   = 1'b0;
    #1;
    test_reset();
    test_single_channel();
    test_backpressure();
    test_round_robin();
    test_w1c_collision();
    test_period_on_tick();
    test_reset_mid_handshake();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
